// File: rtl/vga_pkg.sv
// vga_pkg -- shared definitions for the glyph-to-VRAM writer.
//   DEF_GLYPH_ROWS / DEF_GLYPH_COLS : default glyph geometry (rows, pixels per row)
//   VRAM_ADDR_W                     : VRAM word address width {region, row}
//   wr_state_t                      : writer FSM states
//   glyph_t                         : glyph codes accepted on Letra
//   glyph_row()                     : font bitmap, bit 15 = leftmost pixel
package vga_pkg;

  localparam int DEF_GLYPH_ROWS = 16;
  localparam int DEF_GLYPH_COLS = 16;
  localparam int VRAM_ADDR_W    = 5;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_BLANK = 2'd1,
    ST_FETCH      = 2'd2,
    ST_WRITE      = 2'd3
  } wr_state_t;

  typedef enum logic [1:0] {
    GLYPH_BLANK = 2'd0,
    GLYPH_A     = 2'd1,
    GLYPH_B     = 2'd2,
    GLYPH_SOLID = 2'd3
  } glyph_t;

  function automatic logic [15:0] glyph_row(glyph_t code, logic [3:0] row);
    logic [15:0] a_bits;
    logic [15:0] b_bits;
    case (row)
      4'd1:    begin a_bits = 16'h03C0; b_bits = 16'h1FE0; end
      4'd2:    begin a_bits = 16'h0660; b_bits = 16'h1830; end
      4'd3:    begin a_bits = 16'h0C30; b_bits = 16'h1818; end
      4'd4:    begin a_bits = 16'h0C30; b_bits = 16'h1818; end
      4'd5:    begin a_bits = 16'h1818; b_bits = 16'h1830; end
      4'd6:    begin a_bits = 16'h1818; b_bits = 16'h1FE0; end
      4'd7:    begin a_bits = 16'h1FF8; b_bits = 16'h1FE0; end
      4'd8:    begin a_bits = 16'h1FF8; b_bits = 16'h1830; end
      4'd9:    begin a_bits = 16'h1818; b_bits = 16'h1818; end
      4'd10:   begin a_bits = 16'h1818; b_bits = 16'h1818; end
      4'd11:   begin a_bits = 16'h1818; b_bits = 16'h1818; end
      4'd12:   begin a_bits = 16'h1818; b_bits = 16'h1830; end
      4'd13:   begin a_bits = 16'h1818; b_bits = 16'h1FE0; end
      default: begin a_bits = 16'h0000; b_bits = 16'h0000; end
    endcase
    case (code)
      GLYPH_A:     return a_bits;
      GLYPH_B:     return b_bits;
      GLYPH_SOLID: return 16'hFFFF;
      default:     return 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/vram_writer_if.sv
// vram_writer_if -- command inputs and VRAM write port of the glyph writer.
//   Boton, Region, Letra, VBlank : command side (driven by master)
//   VRAM_WrEn, VRAM_Addr, VRAM_Data, Busy, Done : writer outputs (driven by slave)
interface vram_writer_if
  import vga_pkg::*;
#(
  parameter int DATA_W = DEF_GLYPH_COLS,
  parameter int ADDR_W = VRAM_ADDR_W
);
  logic              Boton;
  logic              Region;
  logic [1:0]        Letra;
  logic              VBlank;
  logic              VRAM_WrEn;
  logic [ADDR_W-1:0] VRAM_Addr;
  logic [DATA_W-1:0] VRAM_Data;
  logic              Busy;
  logic              Done;

  modport master (
    output Boton, Region, Letra, VBlank,
    input  VRAM_WrEn, VRAM_Addr, VRAM_Data, Busy, Done
  );

  modport slave (
    input  Boton, Region, Letra, VBlank,
    output VRAM_WrEn, VRAM_Addr, VRAM_Data, Busy, Done
  );
endinterface

// File: rtl/font_rom.sv
// font_rom -- 4-glyph synchronous font ROM, one word per glyph row.
//   Clk  : clock
//   addr : {glyph code, row}
//   data : glyph row, valid one cycle after addr (registered read)
module font_rom
  import vga_pkg::*;
#(
  parameter  int ROWS  = DEF_GLYPH_ROWS,
  parameter  int COLS  = DEF_GLYPH_COLS,
  localparam int ROW_W = $clog2(ROWS)
) (
  input  logic              Clk,
  input  logic [ROW_W+1:0]  addr,
  output logic [COLS-1:0]   data
);

  logic [COLS-1:0] rom [0:4*ROWS-1];

  genvar gi;
  generate
    for (gi = 0; gi < 4 * ROWS; gi++) begin : g_rom
      assign rom[gi] = COLS'(glyph_row(glyph_t'(gi / ROWS), 4'(gi % ROWS)));
    end
  endgenerate

  always_ff @(posedge Clk) begin
    data <= rom[addr];
  end

endmodule

// File: rtl/vram_writer.sv
// vram_writer -- copies one glyph into a VRAM screen region on a button press,
// writing only while the display is in vertical blanking.
//   Clk  : system clock          Rst : asynchronous active-high reset
//   bus  : vram_writer_if.slave  (Boton/Region/Letra/VBlank in,
//          VRAM_WrEn/VRAM_Addr/VRAM_Data/Busy/Done out)
module vram_writer
  import vga_pkg::*;
#(
  parameter int GLYPH_ROWS = DEF_GLYPH_ROWS,
  parameter int GLYPH_COLS = DEF_GLYPH_COLS
) (
  input  logic         Clk,
  input  logic         Rst,
  vram_writer_if.slave bus
);

  localparam int ROW_W = $clog2(GLYPH_ROWS);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(GLYPH_ROWS - 1);

  // Button synchronizer plus one edge-detect flop; all idle high so that
  // leaving reset never looks like a press.
  logic sync1_reg, sync2_reg, btn_prev_reg;
  logic press;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      sync1_reg    <= 1'b1;
      sync2_reg    <= 1'b1;
      btn_prev_reg <= 1'b1;
    end else begin
      sync1_reg    <= bus.Boton;
      sync2_reg    <= sync1_reg;
      btn_prev_reg <= sync2_reg;
    end
  end

  assign press = btn_prev_reg & ~sync2_reg;

  wr_state_t        state_reg, state_next;
  logic [ROW_W-1:0] row_reg;
  logic             region_reg;
  glyph_t           letra_reg;
  logic             done_reg;
  logic [GLYPH_COLS-1:0] rom_data;

  font_rom #(.ROWS(GLYPH_ROWS), .COLS(GLYPH_COLS)) u_font_rom (
    .Clk  (Clk),
    .addr ({letra_reg, row_reg}),
    .data (rom_data)
  );

  // State register
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  // Command registers and row counter. The counter stops at the last row,
  // so it never wraps inside a command.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      row_reg    <= '0;
      region_reg <= 1'b0;
      letra_reg  <= GLYPH_BLANK;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (press) begin
            region_reg <= bus.Region;
            letra_reg  <= glyph_t'(bus.Letra);
            row_reg    <= '0;
          end
        end
        ST_WRITE: begin
          if (row_reg == LAST_ROW) done_reg <= 1'b1;
          else                     row_reg  <= row_reg + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:       if (press) state_next = ST_WAIT_BLANK;
      ST_WAIT_BLANK: if (bus.VBlank) state_next = ST_FETCH;
      ST_FETCH:      state_next = ST_WRITE;
      ST_WRITE: begin
        if (row_reg == LAST_ROW) state_next = ST_IDLE;
        else if (bus.VBlank)     state_next = ST_FETCH;
        else                     state_next = ST_WAIT_BLANK;
      end
      default:       state_next = ST_IDLE;
    endcase
  end

  // Outputs: the write port is zero except in WRITE, where the ROM word
  // fetched in the preceding FETCH cycle is on rom_data.
  always_comb begin
    bus.VRAM_WrEn = 1'b0;
    bus.VRAM_Addr = '0;
    bus.VRAM_Data = '0;
    bus.Busy      = (state_reg != ST_IDLE);
    bus.Done      = done_reg;
    if (state_reg == ST_WRITE) begin
      bus.VRAM_WrEn = 1'b1;
      bus.VRAM_Addr = {region_reg, row_reg};
      bus.VRAM_Data = rom_data;
    end
  end

endmodule

// File: tb/tb_vram_writer.sv
// tb_vram_writer -- directed bench for vram_writer. A queue holds the VRAM
// writes each command must produce; a negedge monitor checks every cycle.
module tb_vram_writer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vram_writer_if bus ();

  vram_writer dut (
    .Clk (clk),
    .Rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [4:0]  addr;
    logic [15:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  tests = 0;
  int  fails = 0;
  int  cyc = 0;
  int  total_writes = 0;
  int  done_count = 0;
  int  done_cyc = 0;
  int  first_cyc = 0;
  int  last_cyc = 0;
  logic [4:0]  first_addr = '0;
  logic [15:0] first_data = '0;
  bit  cmd_started = 1'b0;
  bit  done_due = 1'b0;
  bit  prev_wren = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected writes of one command: every row once, in row order, at
  // region*ROWS+row, with the glyph's row pattern (only blank and solid used).
  task automatic enqueue_cmd(input int region, input int letra);
    wr_t w;
    for (int r = 0; r < 16; r++) begin
      w.addr = 5'(region * 16 + r);
      w.data = (letra == 3) ? 16'hFFFF : 16'h0000;
      exp_q.push_back(w);
    end
    cmd_started = 1'b0;
  endtask

  always @(posedge clk) cyc++;

  // Per-cycle compare against the expected write queue and Done timing.
  always @(negedge clk) begin
    bit exp_done;
    wr_t w;
    exp_done = done_due;
    done_due = 1'b0;
    if (bus.VRAM_WrEn) begin
      total_writes++;
      chk("busy_in_write", bus.Busy, 1);
      chk("no_back_to_back", prev_wren, 0);
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write: addr %0d data %0h, expected none", bus.VRAM_Addr, bus.VRAM_Data);
      end else begin
        w = exp_q.pop_front();
        chk("wr_addr", bus.VRAM_Addr, w.addr);
        chk("wr_data", bus.VRAM_Data, w.data);
        if (!cmd_started) begin
          cmd_started = 1'b1;
          first_cyc  = cyc;
          first_addr = bus.VRAM_Addr;
          first_data = bus.VRAM_Data;
        end
        last_cyc = cyc;
        if (exp_q.size() == 0) done_due = 1'b1;
      end
    end else begin
      chk("idle_addr", bus.VRAM_Addr, 0);
      chk("idle_data", bus.VRAM_Data, 0);
    end
    prev_wren = bus.VRAM_WrEn;
    chk("done", bus.Done, exp_done);
    if (exp_done) chk("busy_at_done", bus.Busy, 0);
    if (bus.Done) begin
      done_count++;
      done_cyc = cyc;
    end
  end

  task automatic pulse_boton(input int low_cycles);
    @(negedge clk);
    bus.Boton = 1'b0;
    repeat (low_cycles) @(negedge clk);
    bus.Boton = 1'b1;
  endtask

  task automatic wait_done(input string name, input int budget);
    int start = done_count;
    int n = 0;
    while (done_count == start && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, done_count != start, 1);
  endtask

  task automatic wait_row(input string name, input int row, input int budget);
    int n = 0;
    bit hit = 1'b0;
    while (!hit && n < budget) begin
      @(negedge clk);
      n++;
      if (bus.VRAM_WrEn && bus.VRAM_Addr[3:0] == 4'(row)) hit = 1'b1;
    end
    chk(name, hit, 1);
  endtask

  initial begin
    int w0, d0;
    bus.Boton = 1'b1; bus.Region = 1'b0; bus.Letra = 2'd0; bus.VBlank = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", bus.Busy, 0);
    chk("rst_done", bus.Done, 0);
    chk("rst_wren", bus.VRAM_WrEn, 0);
    chk("rst_addr", bus.VRAM_Addr, 0);
    chk("rst_data", bus.VRAM_Data, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Solid glyph, right region, VBlank always high.
    bus.VBlank = 1'b1; bus.Region = 1'b1; bus.Letra = 2'd3;
    w0 = total_writes; d0 = done_count;
    enqueue_cmd(1, 3);
    pulse_boton(4);
    wait_done("t1_timeout", 100);
    chk("t1_first_addr", first_addr, 16);
    chk("t1_first_data", first_data, 16'hFFFF);
    chk("t1_write_span", last_cyc - first_cyc, 30);
    chk("t1_done_latency", done_cyc - first_cyc, 31);
    repeat (10) @(negedge clk);
    chk("t1_writes", total_writes - w0, 16);
    chk("t1_dones", done_count - d0, 1);

    // Blank glyph, left region, VBlank held low for 50 cycles.
    bus.VBlank = 1'b0; bus.Region = 1'b0; bus.Letra = 2'd0;
    w0 = total_writes;
    enqueue_cmd(0, 0);
    pulse_boton(4);
    repeat (50) @(negedge clk);
    chk("t2_no_write_low", total_writes - w0, 0);
    chk("t2_busy_wait", bus.Busy, 1);
    bus.VBlank = 1'b1;
    wait_done("t2_timeout", 100);
    chk("t2_first_addr", first_addr, 0);
    chk("t2_writes", total_writes - w0, 16);

    // VBlank drops after row 5, stalls, resumes at row 6.
    repeat (5) @(negedge clk);
    bus.Region = 1'b1; bus.Letra = 2'd3;
    w0 = total_writes;
    enqueue_cmd(1, 3);
    pulse_boton(4);
    wait_row("t3_row5_seen", 5, 100);
    bus.VBlank = 1'b0;
    repeat (20) @(negedge clk);
    chk("t3_stall_writes", total_writes - w0, 6);
    chk("t3_busy_stall", bus.Busy, 1);
    bus.VBlank = 1'b1;
    wait_done("t3_timeout", 100);
    chk("t3_writes", total_writes - w0, 16);

    // Second press while busy with other Region/Letra is dropped.
    repeat (5) @(negedge clk);
    bus.Region = 1'b1; bus.Letra = 2'd3;
    w0 = total_writes; d0 = done_count;
    enqueue_cmd(1, 3);
    pulse_boton(4);
    wait_row("t4_row2_seen", 2, 100);
    bus.Region = 1'b0; bus.Letra = 2'd0;
    pulse_boton(4);
    wait_done("t4_timeout", 100);
    repeat (40) @(negedge clk);
    chk("t4_writes", total_writes - w0, 16);
    chk("t4_dones", done_count - d0, 1);

    // Reset during the row 8 FETCH aborts the command.
    bus.Region = 1'b0; bus.Letra = 2'd3;
    w0 = total_writes; d0 = done_count;
    enqueue_cmd(0, 3);
    pulse_boton(4);
    wait_row("t5_row7_seen", 7, 100);
    @(negedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    done_due = 1'b0;
    #1;
    chk("t5_rst_busy", bus.Busy, 0);
    chk("t5_rst_wren", bus.VRAM_WrEn, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("t5_partial_writes", total_writes - w0, 8);
    chk("t5_no_done", done_count - d0, 0);
    chk("t5_idle_busy", bus.Busy, 0);
    bus.Region = 1'b1; bus.Letra = 2'd0;
    w0 = total_writes;
    enqueue_cmd(1, 0);
    pulse_boton(4);
    wait_done("t5_rerun_timeout", 100);
    chk("t5_rerun_writes", total_writes - w0, 16);

    // One-cycle bounce then held low: a single command.
    repeat (5) @(negedge clk);
    bus.Region = 1'b1; bus.Letra = 2'd0;
    w0 = total_writes; d0 = done_count;
    enqueue_cmd(1, 0);
    @(negedge clk); bus.Boton = 1'b0;
    @(negedge clk); bus.Boton = 1'b1;
    @(negedge clk); bus.Boton = 1'b0;
    wait_done("t6_timeout", 100);
    repeat (60) @(negedge clk);
    chk("t6_writes", total_writes - w0, 16);
    chk("t6_dones", done_count - d0, 1);
    bus.Boton = 1'b1;
    repeat (10) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
